alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode/issue stage that drives the ALU's input interface. It accepts 16-bit instructions with a valid/ready handshake and decodes them into the ALU's 12-bit one-hot `alusignals`. It reads operands from the external register file, blocks RAW/WAW hazards with a register scoreboard, and presents a registered issue bundle (`alusignals`, `instrout`, `op1`, `op2`, `immx`, `isimmediate`) to the ALU.

## Interface
- `NREGS`, 8: architectural registers; must be 8, since register indices are 3 bits.
- `STALL_W`, 16: width of the saturating hazard-stall counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid` input 1: an instruction is offered.
- `in_instr` input 16: the offered instruction.
- `in_ready` output 1: the instruction is accepted when `in_valid && in_ready`.
- `rs1_addr`, `rs2_addr` outputs 3: register-file read addresses, combinational from `in_instr`.
- `rs1_data`, `rs2_data` inputs 16: register-file read data, valid in the same cycle as the addresses.
- `issue_valid` output 1: the issue bundle is valid.
- `alu_ready` input 1: the ALU consumes the bundle when `issue_valid && alu_ready`.
- `alusignals` output 12: one-hot operation select. Bit order: add, ld, st, sub, mul, cmp, mov, or, and, not, lsl, lsr (bit 0 = add).
- `instrout` output 16: the issued instruction.
- `op1`, `op2` outputs 16: operand values.
- `immx` output 5: `instr[4:0]`.
- `isimmediate` output 1: `instr[11]`.
- `wb_valid` input 1: writeback of a destination register completes this cycle.
- `wb_rd` input 3: register index being written back.
- `illegal_err` output 1: sticky; set when an illegal opcode is accepted.
- `stall_cnt` output STALL_W: saturating count of hazard-stall cycles.

## Operation
- **Encoding:** `[15:12]` opcode, `[11]` I, `[10:8]` rd, `[7:5]` rs1, `[4:2]` rs2, `[4:0]` imm.
- **Opcode map:** 0 add, 1 ld, 2 st, 3 sub, 4 mul, 5 cmp, 6 mov, 7 or, 8 and, 9 not, 10 lsl, 11 lsr. Opcodes 12–15 are illegal.
- **Decode:** `alusignals` = 1 << opcode.
- **Operands:**
  - `op1` = R[rs1].
  - `op2` = R[rs2]. When I=1, `op2` = 0 and the ALU uses `immx`.
- **Source registers checked for hazards:**
  - rs1: all ops except mov.
  - rs2: all ops except not, and only when I=0.
  - rd: st only (store data is read later by the memory stage).
- **Destination (sets a busy bit):** every op except st and cmp.
- **Scoreboard:** 8 busy bits.
  - Issuing an op that writes rd sets busy[rd].
  - `wb_valid` clears busy[wb_rd].
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - There is no bypass: a clear becomes visible to hazard checks in the following cycle.
- **Hazard:** any checked source register is busy, or the destination register is busy (WAW).
- **Ready:** `in_ready` = (!`issue_valid` || `alu_ready`) && !hazard(`in_instr`).
  - The hazard term is forced to 0 for illegal opcodes.
  - `in_ready` is combinational and must not depend on `in_valid`.
- **Illegal opcode:**
  - The instruction is accepted and dropped; no bundle is issued.
  - `illegal_err` is set and stays set until reset.
- **Stall counter:** increments in each cycle where `in_valid` is high and a hazard is blocking. It saturates at all-ones.
- **Reset** (rst_n=0 at a clock edge) clears:
  - `issue_valid`, `alusignals`, `instrout`, `op1`, `op2`, `immx`, `isimmediate`
  - the busy bits, `illegal_err`, `stall_cnt`

  Reset in the middle of a hold discards the held bundle.

## Timing
- Latency: an instruction accepted at edge N appears on the bundle with `issue_valid`=1 after edge N.
- Throughput: one instruction per cycle when there are no hazards and `alu_ready`=1.
- **Hold:** while `issue_valid && !alu_ready`, every bundle output is stable and `in_ready`=0.
- **Drain:** if the bundle is consumed and there is no new accept in the same cycle, `issue_valid` falls after that edge.
- **Back-to-back dependence:** I1 writes r1 and I2 reads r1. I2 stalls until the cycle after `wb_valid`/`wb_rd`=1. It is accepted in that cycle at the earliest.
- Register-file data is sampled only on the accept edge.

## Configuration
- `ALU_ISSUE_SCOREBOARD_EN` defined:
  - The scoreboard, hazard logic and `stall_cnt` behave as described above.
- `ALU_ISSUE_SCOREBOARD_EN` undefined:
  - There are no busy bits and hazard is constant 0.
  - `wb_valid`/`wb_rd` are ignored.
  - `stall_cnt` is tied to 0.
  - `in_ready` = !`issue_valid` || `alu_ready`.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles -> all outputs 0, `in_ready`=1.
- **Add, register form:** R1=0x0001, R2=0x0005, issue add r3,r1,r2 (0x0328) -> next cycle `issue_valid`=1, `alusignals`=0x001, `op1`=0x0001, `op2`=0x0005, `isimmediate`=0.
- **lsl, immediate form:** issue lsl r4,r1,#2 (0xAC22) -> `alusignals`=0x400, `op2`=0, `immx`=0x02, `isimmediate`=1.
- **RAW hazard:** issue add r3,.. then sub r5,r3,r2 -> `in_ready`=0 and `stall_cnt` counts. Pulse `wb_valid`/`wb_rd`=3 -> sub accepted the next cycle, `alusignals`=0x008.
- **Backpressure:** hold `alu_ready`=0 for 3 cycles with `issue_valid`=1 -> bundle stable and `in_ready`=0. Raise `alu_ready` -> next instruction accepted in the same cycle.
- **Illegal opcode:** issue 0xF000 -> accepted, `issue_valid` stays 0, `illegal_err`=1 until reset.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes 16-bit instructions into a registered ALU issue bundle.
// Ports: clk, rst_n (sync, active-low); in_valid/in_instr/in_ready accept handshake;
//   rs1_addr/rs2_addr -> register file, rs1_data/rs2_data <- register file;
//   issue_valid/alu_ready bundle handshake; alusignals, instrout, op1, op2, immx,
//   isimmediate bundle; wb_valid/wb_rd writeback; illegal_err, stall_cnt status.
// Define ALU_ISSUE_SCOREBOARD_EN to enable the RAW/WAW register scoreboard.
module alu_issue_stage #(
    parameter int unsigned NREGS   = 8,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [15:0]        in_instr,
    output logic               in_ready,
    output logic [2:0]         rs1_addr,
    output logic [2:0]         rs2_addr,
    input  logic [15:0]        rs1_data,
    input  logic [15:0]        rs2_data,
    output logic               issue_valid,
    input  logic               alu_ready,
    output logic [11:0]        alusignals,
    output logic [15:0]        instrout,
    output logic [15:0]        op1,
    output logic [15:0]        op2,
    output logic [4:0]         immx,
    output logic               isimmediate,
    input  logic               wb_valid,
    input  logic [2:0]         wb_rd,
    output logic               illegal_err,
    output logic [STALL_W-1:0] stall_cnt
);

    logic [3:0] opc;
    logic       is_imm;
    logic       illegal;
    logic       hazard;
    logic       accept;

    assign opc      = in_instr[15:12];
    assign is_imm   = in_instr[11];
    assign illegal  = (opc > 4'd11);
    assign rs1_addr = in_instr[7:5];
    assign rs2_addr = in_instr[4:2];

    logic        issue_valid_q, issue_valid_d;
    logic [11:0] alusignals_q, alusignals_d;
    logic [15:0] instrout_q, instrout_d;
    logic [15:0] op1_q, op1_d;
    logic [15:0] op2_q, op2_d;
    logic [4:0]  immx_q, immx_d;
    logic        isimmediate_q, isimmediate_d;
    logic        illegal_err_q, illegal_err_d;

    assign in_ready = (!issue_valid_q || alu_ready) && !hazard;
    assign accept   = in_valid && in_ready;

`ifdef ALU_ISSUE_SCOREBOARD_EN
    logic [2:0]         rd;
    logic               is_st, is_cmp, is_mov, is_not, wr_rd;
    logic               hz_rs1, hz_rs2, hz_rd;
    logic [NREGS-1:0]   busy_q, busy_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    assign rd     = in_instr[10:8];
    assign is_st  = (opc == 4'd2);
    assign is_cmp = (opc == 4'd5);
    assign is_mov = (opc == 4'd6);
    assign is_not = (opc == 4'd9);
    assign wr_rd  = !illegal && !is_st && !is_cmp;

    // st reads rd as store data; every writer checks rd for WAW.
    assign hz_rs1 = !is_mov && busy_q[rs1_addr];
    assign hz_rs2 = !is_not && !is_imm && busy_q[rs2_addr];
    assign hz_rd  = (is_st || wr_rd) && busy_q[rd];
    assign hazard = !illegal && (hz_rs1 || hz_rs2 || hz_rd);

    always_comb begin
        busy_d      = busy_q;
        stall_cnt_d = stall_cnt_q;
        // Clear first so a same-cycle set on the same register wins.
        if (wb_valid) busy_d[wb_rd] = 1'b0;
        if (accept && wr_rd) busy_d[rd] = 1'b1;
        if (in_valid && hazard && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_sb;

    assign hazard    = 1'b0;
    assign stall_cnt = '0;
    assign unused_sb = ^{wb_valid, wb_rd, 1'(NREGS)};
`endif

    always_comb begin
        issue_valid_d = issue_valid_q;
        alusignals_d  = alusignals_q;
        instrout_d    = instrout_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        immx_d        = immx_q;
        isimmediate_d = isimmediate_q;
        illegal_err_d = illegal_err_q;
        // Illegal opcodes are swallowed: accepted, flagged, never issued.
        if (accept && illegal) illegal_err_d = 1'b1;
        if (accept && !illegal) begin
            issue_valid_d = 1'b1;
            alusignals_d  = 12'd1 << opc;
            instrout_d    = in_instr;
            op1_d         = rs1_data;
            op2_d         = is_imm ? 16'd0 : rs2_data;
            immx_d        = in_instr[4:0];
            isimmediate_d = is_imm;
        end else if (alu_ready) begin
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_valid_q <= 1'b0;
            alusignals_q  <= '0;
            instrout_q    <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            immx_q        <= '0;
            isimmediate_q <= 1'b0;
            illegal_err_q <= 1'b0;
        end else begin
            issue_valid_q <= issue_valid_d;
            alusignals_q  <= alusignals_d;
            instrout_q    <= instrout_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            immx_q        <= immx_d;
            isimmediate_q <= isimmediate_d;
            illegal_err_q <= illegal_err_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign alusignals  = alusignals_q;
    assign instrout    = instrout_q;
    assign op1         = op1_q;
    assign op2         = op2_q;
    assign immx        = immx_q;
    assign isimmediate = isimmediate_q;
    assign illegal_err = illegal_err_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed plus randomized bench for alu_issue_stage.
// Compares the DUT every cycle against an instruction-level model.
`timescale 1ns/1ps
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic [2:0]  rs1_addr, rs2_addr;
    logic [15:0] rs1_data, rs2_data;
    logic        issue_valid;
    logic        alu_ready;
    logic [11:0] alusignals;
    logic [15:0] instrout, op1, op2;
    logic [4:0]  immx;
    logic        isimmediate;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic        illegal_err;
    logic [15:0] stall_cnt;

    logic [15:0] rf [8];

    int nchk = 0;
    int nerr = 0;

    alu_issue_stage #(.NREGS(8), .STALL_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .alu_ready(alu_ready),
        .alusignals(alusignals), .instrout(instrout),
        .op1(op1), .op2(op2), .immx(immx), .isimmediate(isimmediate),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .illegal_err(illegal_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    bit          known = 0;
    bit          mfresh;
    bit          mbusy [8];
    bit          mv, m_err, m_isimm;
    logic [11:0] m_alu;
    logic [15:0] m_instr, m_op1, m_op2;
    logic [4:0]  m_immx;
    int          m_stall;

    function automatic bit m_writes(logic [15:0] i);
        int op;
        op = int'(i[15:12]);
        return (op < 12) && (op != 2) && (op != 5);
    endfunction

    function automatic bit m_hazard(logic [15:0] i);
`ifdef ALU_ISSUE_SCOREBOARD_EN
        int op;
        op = int'(i[15:12]);
        if (op >= 12) return 1'b0;
        if (op != 6 && mbusy[i[7:5]]) return 1'b1;
        if (op != 9 && !i[11] && mbusy[i[4:2]]) return 1'b1;
        if (op != 5 && mbusy[i[10:8]]) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        bit          hz, rdy, acc;
        logic [15:0] i;
        i   = in_instr;
        hz  = m_hazard(i);
        rdy = (!mv || alu_ready) && !hz;
        if (known) begin
            chk("in_ready", 32'(in_ready), 32'(rdy));
            chk("rs1_addr", 32'(rs1_addr), 32'(i[7:5]));
            chk("rs2_addr", 32'(rs2_addr), 32'(i[4:2]));
            chk("issue_valid", 32'(issue_valid), 32'(mv));
            chk("illegal_err", 32'(illegal_err), 32'(m_err));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            if (mv || mfresh) begin
                chk("alusignals", 32'(alusignals), 32'(m_alu));
                chk("instrout", 32'(instrout), 32'(m_instr));
                chk("op1", 32'(op1), 32'(m_op1));
                chk("op2", 32'(op2), 32'(m_op2));
                chk("immx", 32'(immx), 32'(m_immx));
                chk("isimmediate", 32'(isimmediate), 32'(m_isimm));
            end
        end
        if (!rst_n) begin
            known = 1; mfresh = 1; mv = 0; m_err = 0; m_stall = 0;
            m_alu = '0; m_instr = '0; m_op1 = '0; m_op2 = '0;
            m_immx = '0; m_isimm = 0;
            foreach (mbusy[k]) mbusy[k] = 0;
        end else if (known) begin
            acc = in_valid && rdy;
            if (in_valid && hz && m_stall < 65535) m_stall++;
`ifdef ALU_ISSUE_SCOREBOARD_EN
            if (wb_valid) mbusy[wb_rd] = 0;
`endif
            if (acc && i[15:12] >= 4'd12) m_err = 1;
            if (acc && i[15:12] < 4'd12) begin
                mv = 1; mfresh = 0;
                m_alu   = 12'h001 << i[15:12];
                m_instr = i;
                m_op1   = rf[i[7:5]];
                m_op2   = i[11] ? 16'h0000 : rf[i[4:2]];
                m_immx  = i[4:0];
                m_isimm = i[11];
                if (m_writes(i)) mbusy[i[10:8]] = 1;
            end else if (alu_ready) begin
                mv = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(bit v, logic [15:0] ins, bit ardy, bit wbv, logic [2:0] wr);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = ins;
        alu_ready = ardy;
        wb_valid  = wbv;
        wb_rd     = wr;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_instr = '0; alu_ready = 1;
        wb_valid = 0; wb_rd = '0;
        for (int k = 0; k < 8; k++) rf[k] = 16'(k * 16'h1111);
        rf[1] = 16'h0001;
        rf[2] = 16'h0005;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_issue_valid", 32'(issue_valid), 32'h0);
        chk("rst_alusignals", 32'(alusignals), 32'h0);
        chk("rst_op1", 32'(op1), 32'h0);
        chk("rst_op2", 32'(op2), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_illegal_err", 32'(illegal_err), 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        @(posedge clk);
        #1 rst_n = 1;

        // add r3, r1, r2
        drive(1, 16'h0328, 1, 0, 0);
        drive(0, 16'h0000, 1, 0, 0);
        @(negedge clk);
        chk("add_valid", 32'(issue_valid), 32'h1);
        chk("add_alu", 32'(alusignals), 32'h001);
        chk("add_op1", 32'(op1), 32'h0001);
        chk("add_op2", 32'(op2), 32'h0005);
        chk("add_isimm", 32'(isimmediate), 32'h0);
        chk("model_add_alu", 32'(m_alu), 32'h001);

        // lsl r4, r1, #2
        drive(1, 16'hAC22, 1, 0, 0);
        drive(0, 16'h0000, 1, 1, 4);
        @(negedge clk);
        chk("lsl_alu", 32'(alusignals), 32'h400);
        chk("lsl_op2", 32'(op2), 32'h0000);
        chk("lsl_immx", 32'(immx), 32'h02);
        chk("lsl_isimm", 32'(isimmediate), 32'h1);
        chk("model_lsl_op2", 32'(m_op2), 32'h0000);

        // sub r5, r3, r2 after add r3
`ifdef ALU_ISSUE_SCOREBOARD_EN
        repeat (3) begin
            drive(1, 16'h3568, 1, 0, 0);
            @(negedge clk);
            chk("raw_stall_ready", 32'(in_ready), 32'h0);
        end
        drive(1, 16'h3568, 1, 1, 3);
        @(negedge clk);
        chk("raw_wb_cycle_ready", 32'(in_ready), 32'h0);
        chk("raw_stall_cnt3", 32'(stall_cnt), 32'd3);
        drive(1, 16'h3568, 1, 0, 0);
        @(negedge clk);
        chk("raw_after_wb_ready", 32'(in_ready), 32'h1);
        chk("raw_stall_cnt4", 32'(stall_cnt), 32'd4);
        chk("model_stall4", 32'(m_stall), 32'd4);
`else
        drive(1, 16'h3568, 1, 0, 0);
        @(negedge clk);
        chk("sub_ready", 32'(in_ready), 32'h1);
`endif
        drive(0, 16'h0000, 1, 0, 0);
        @(negedge clk);
        chk("sub_alu", 32'(alusignals), 32'h008);
        chk("sub_valid", 32'(issue_valid), 32'h1);
        drive(0, 16'h0000, 1, 1, 5);
        drive(0, 16'h0000, 1, 1, 3);

        // backpressure: add held while or r6,r1,r2 waits
        drive(1, 16'h0328, 1, 0, 0);
        repeat (3) begin
            drive(1, 16'h7628, 0, 0, 0);
            @(negedge clk);
            chk("hold_ready", 32'(in_ready), 32'h0);
            chk("hold_valid", 32'(issue_valid), 32'h1);
            chk("hold_alu", 32'(alusignals), 32'h001);
            chk("hold_op2", 32'(op2), 32'h0005);
        end
        drive(1, 16'h7628, 1, 0, 0);
        @(negedge clk);
        chk("release_ready", 32'(in_ready), 32'h1);
        drive(0, 16'h0000, 1, 1, 3);
        @(negedge clk);
        chk("or_alu", 32'(alusignals), 32'h080);
        drive(0, 16'h0000, 1, 1, 6);

        // illegal opcode
        drive(1, 16'hF000, 1, 0, 0);
        @(negedge clk);
        chk("illegal_ready", 32'(in_ready), 32'h1);
        drive(0, 16'h0000, 1, 0, 0);
        @(negedge clk);
        chk("illegal_no_issue", 32'(issue_valid), 32'h0);
        chk("illegal_err_set", 32'(illegal_err), 32'h1);
        drive(0, 16'h0000, 1, 0, 0);
        @(negedge clk);
        chk("illegal_err_sticky", 32'(illegal_err), 32'h1);

        // randomized traffic, with one reset in the middle
        for (int c = 0; c < 4000; c++) begin
            logic [3:0]  op;
            logic [11:0] rest;
            op   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                               : 4'($urandom_range(0, 11));
            rest = 12'($urandom);
            drive($urandom_range(0, 3) != 0, {op, rest},
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  3'($urandom_range(0, 7)));
            rf[$urandom_range(0, 7)] = 16'($urandom);
            rst_n = (c != 2000);
        end

        drive(0, 16'h0000, 1, 0, 0);
        rst_n = 0;
        drive(0, 16'h0000, 1, 0, 0);
        rst_n = 1;
        @(negedge clk);
        chk("final_rst_err", 32'(illegal_err), 32'h0);
        chk("final_rst_valid", 32'(issue_valid), 32'h0);
        chk("final_rst_stall", 32'(stall_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
